// File: rtl/tt_arb_pkg.sv
// tt_arb_pkg: state encodings, sizing and uo_out bit positions shared by the 8-way arbiter
package tt_arb_pkg;
  localparam int N_REQ = 8;
  localparam int CNT_W = 4;
  localparam int IDX_W = 3;
  localparam int UO_IDX = 0;
  localparam int UO_VALID = 3;
  localparam int UO_TO = 4;
  localparam int UO_BUSY = 5;
  localparam int UO_ST = 6;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_GAP = 2'd2} state_t;
endpackage

// File: rtl/tt_arb_if.sv
// tt_arb_if: Tiny Tapeout pin bundle of the arbiter; master drives inputs, slave drives outputs
interface tt_arb_if;
  logic ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select, fixed (highest index) or round-robin from last+1
module arb_pick import tt_arb_pkg::*; #(
  parameter int NR = N_REQ
) (
  input  logic [NR-1:0]    req,
  input  logic [IDX_W-1:0] last,
  input  logic             mode,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  // scan from lowest priority to highest so the last hit is the winner
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = NR - 1; i >= 0; i--)
      if (mode ? req[(int'(last) + 1 + i) % NR] : req[NR - 1 - i])
        idx = mode ? IDX_W'((int'(last) + 1 + i) % NR) : IDX_W'(NR - 1 - i);
  end
endmodule

// File: rtl/tt_um_rr_arb8.sv
// tt_um_rr_arb8: 8-way fixed/round-robin arbiter, IDLE -> GRANT -> GAP; define ARB_TIMEOUT_EN
// to add a hold-limit timeout (limit L on uio_in[7:4], pulse on uo_out[4]).
module tt_um_rr_arb8 #(
  parameter int N_REQ = tt_arb_pkg::N_REQ,
  parameter int CNT_W = tt_arb_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import tt_arb_pkg::*;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d, pick_idx;
  logic pick_any, to_q, to_d, rel, tmo, unused;
  assign uio_out = '0;
  assign uio_oe = '0;
  // dropping the granted request counts as a release
  assign rel = uio_in[0] | ~ui_in[idx_q];
  arb_pick #(.NR(N_REQ)) u_pick (
    .req (ui_in[N_REQ-1:0]),
    .last(last_q),
    .mode(uio_in[1]),
    .idx (pick_idx),
    .any (pick_any)
  );
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, lim_q, lim_d;
  assign unused = ^{ena, uio_in[3:2]};
  assign tmo = lim_q != '0 && cnt_q == lim_q && !rel;
  always_comb begin
    cnt_d = state_q == ST_GRANT ? cnt_q + CNT_W'(1) : CNT_W'(1);
    lim_d = state_q == ST_IDLE ? CNT_W'(uio_in[7:4]) : lim_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
`else
  localparam int unused_cnt_w = CNT_W;
  assign unused = ^{ena, uio_in[7:2]};
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = pick_any ? ST_GRANT : ST_IDLE;
      ST_GRANT: state_d = rel || tmo ? ST_GAP : ST_GRANT;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    idx_d = state_q == ST_IDLE ? pick_idx : idx_q;
    last_d = state_q == ST_GRANT && state_d == ST_GAP ? idx_q : last_q;
    to_d = state_q == ST_GRANT && tmo;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      idx_q <= '0;
      last_q <= IDX_W'(N_REQ - 1);
      to_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      last_q <= last_d;
      to_q <= to_d;
    end
  always_comb begin
    uo_out = '0;
    uo_out[UO_IDX +: IDX_W] = state_q == ST_GRANT ? idx_q : '0;
    uo_out[UO_VALID] = state_q == ST_GRANT;
    uo_out[UO_TO] = to_q;
    uo_out[UO_BUSY] = state_q != ST_IDLE;
    uo_out[UO_ST +: 2] = state_q;
  end
endmodule

// File: tb/tb_tt_um_rr_arb8.sv
// tb_tt_um_rr_arb8: directed scenarios plus random traffic against a cycle-level arbiter model
module tb_tt_um_rr_arb8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int m_st, m_idx, m_last, m_cnt, m_lim;
  logic m_to;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  tt_arb_if pins ();
  tt_um_rr_arb8 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (pins.ena),
    .ui_in  (pins.ui_in),
    .uio_in (pins.uio_in),
    .uo_out (pins.uo_out),
    .uio_out(pins.uio_out),
    .uio_oe (pins.uio_oe)
  );
  always #5 clk = ~clk;

  function automatic int winner(logic [7:0] r, logic md, int last);
    if (!md) begin
      for (int j = 7; j >= 0; j--) if (r[j]) return j;
    end else begin
      for (int k = 1; k <= 8; k++) if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return 0;
  endfunction

  function automatic logic [7:0] exp_uo();
    logic [7:0] e;
    e = '0;
    e[7:6] = 2'(m_st);
    e[5] = m_st != 0;
    e[4] = m_to;
    e[3] = m_st == 1;
    e[2:0] = m_st == 1 ? 3'(m_idx) : 3'd0;
    return e;
  endfunction

  task automatic model_step();
    logic [7:0] r;
    logic rl, tm;
    r = pins.ui_in;
    if (!rst_n) begin
      m_st = 0; m_idx = 0; m_last = 7; m_cnt = 0; m_lim = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_st == 0) begin
      if (r != 0) begin
        m_idx = winner(r, pins.uio_in[1], m_last);
        m_st = 1;
        m_cnt = 1;
        m_lim = int'(pins.uio_in[7:4]);
      end
    end else if (m_st == 1) begin
      rl = pins.uio_in[0] || !r[m_idx];
      tm = TO_EN && m_lim != 0 && m_cnt == m_lim && !rl;
      if (rl || tm) begin
        m_st = 2;
        m_last = m_idx;
        m_to = tm;
      end else m_cnt++;
    end else m_st = 0;
  endtask

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("uo_out_model", pins.uo_out, exp_uo());
    check("uio_out_oe", pins.uio_out | pins.uio_oe, 8'h00);
  endtask

  task automatic drive(logic [7:0] req, logic mode, logic rel, logic [3:0] lim);
    pins.ui_in = req;
    pins.uio_in = {lim, 2'b00, mode, rel};
  endtask

  initial begin
    pins.ena = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    tick();
    check("reset_uo", pins.uo_out, 8'h00);
    rst_n = 1'b1;
    tick();
    check("idle_no_req", pins.uo_out, 8'h00);
    // fixed priority: highest index wins, release -> GAP -> IDLE
    drive(8'b0010_0100, 1'b0, 1'b0, 4'd0);
    tick();
    check("fixed_grant5", pins.uo_out, 8'h6D);
    tick();
    check("fixed_hold", pins.uo_out, 8'h6D);
    drive(8'b0010_0100, 1'b1, 1'b1, 4'd0);
    tick();
    check("fixed_gap", pins.uo_out, 8'hA0);
    drive(8'h00, 1'b0, 1'b1, 4'd0);
    tick();
    check("fixed_idle", pins.uo_out, 8'h00);
    // round-robin rotation from reset: 0..7 then 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int g = 0; g < 9; g++) begin
      drive(8'hFF, 1'b1, 1'b0, 4'd0);
      tick();
      check("rr_grant", pins.uo_out, 8'h68 | 8'(g % 8));
      drive(8'hFF, 1'b0, 1'b1, 4'd0);
      tick();
      check("rr_gap", pins.uo_out, 8'hA0);
      drive(8'hFF, 1'b1, 1'b0, 4'd0);
      tick();
      check("rr_idle", pins.uo_out, 8'h00);
    end
    // wrap-around: last=6, req {1,0} -> 0
    drive(8'h40, 1'b1, 1'b0, 4'd0);
    tick();
    check("rr_grant6", pins.uo_out, 8'h6E);
    drive(8'h00, 1'b1, 1'b0, 4'd0);
    tick();
    check("implicit_release_gap", pins.uo_out, 8'hA0);
    drive(8'h03, 1'b1, 1'b0, 4'd0);
    tick();
    tick();
    check("rr_wrap0", pins.uo_out, 8'h68);
    // reset mid-GRANT: outputs clear, last back to 7
    rst_n = 1'b0;
    tick();
    check("reset_mid_grant", pins.uo_out, 8'h00);
    rst_n = 1'b1;
    drive(8'h81, 1'b1, 1'b0, 4'd0);
    tick();
    check("post_reset_rr0", pins.uo_out, 8'h68);
`ifdef ARB_TIMEOUT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(8'h04, 1'b0, 1'b0, 4'd3);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("to_hold", pins.uo_out, 8'h6A);
    end
    tick();
    check("to_pulse", pins.uo_out, 8'hB0);
    tick();
    check("to_idle", pins.uo_out, 8'h00);
    tick();
    check("to_regrant", pins.uo_out, 8'h6A);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(8'h04, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("l0_hold", pins.uo_out, 8'h6A);
    end
    // release on the limit cycle beats the timeout
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(8'h04, 1'b0, 1'b0, 4'd2);
    tick();
    tick();
    drive(8'h04, 1'b0, 1'b1, 4'd2);
    tick();
    check("release_wins", pins.uo_out, 8'hA0);
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) pins.ui_in = 8'($urandom);
      else if ($urandom_range(0, 7) == 0) pins.ui_in = 8'h00;
      pins.uio_in = {4'($urandom_range(0, 5)), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0)};
      pins.ena = 1'($urandom);
      rst_n = $urandom_range(0, 49) != 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_um_rr_arb8.md
TT_UM_RR_ARB8 -- requirements
Module: tt_um_rr_arb8

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: ena  input  1  power-good, ignored.
REQ-004 SHALL have ports: ui_in  input  8  req[7:0], one request line per requester.
REQ-005 SHALL have ports: uio_in  input  8  [0] release, [1] mode (0 fixed, 1 round-robin), [3:2] unused, [7:4] hold limit L.
REQ-006 SHALL have ports: uo_out  output  8  [2:0] grant index, [3] grant_valid, [4] timeout pulse, [5] busy, [7:6] state code.
REQ-007 SHALL have ports: uio_out  output  8  constant 0.
REQ-008 SHALL have ports: uio_oe  output  8  constant 0 (all bidirectionals inputs).
REQ-009 SHALL have parameter defaults: N_REQ = 8, number of requesters; CNT_W = 4, hold-counter width.

Function
REQ-010 SHALL implement FSM IDLE (code 0), GRANT (1), GAP (2); code 3 unreachable, recovers to IDLE.
REQ-011 IDLE: if any req bit set, SHALL register winner index, set grant_valid, enter GRANT on that edge (1-cycle latency req->grant).
REQ-012 mode and winner SHALL be sampled only in IDLE; changes during GRANT/GAP have no effect until next IDLE.
REQ-013 Fixed mode: highest asserted req index SHALL win.
REQ-014 Round-robin mode: search SHALL start at (last+1) mod 8, ascending with wrap; first asserted index wins.
REQ-015 last SHALL update to the granted index on every GRANT->GAP exit, in both modes.
REQ-016 GRANT: grant index and grant_valid SHALL hold stable until exit.
REQ-017 GRANT exit to GAP SHALL occur on release=1, or on the granted requester's req bit low (implicit release), or on timeout (REQ-026).
REQ-018 GAP SHALL last exactly one cycle with grant_valid=0, then return to IDLE unconditionally.
REQ-019 No req in IDLE: SHALL remain in IDLE with grant_valid=0.
REQ-020 release in IDLE or GAP SHALL be ignored.
REQ-021 busy SHALL be 1 in GRANT and GAP, 0 in IDLE.
REQ-022 grant index SHALL read 0 whenever grant_valid=0.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to uo_out.

Reset
REQ-024 rst_n low at a rising edge SHALL force state IDLE, last=7, hold counter 0, and uo_out=0 on that edge, including mid-GRANT; it SHALL NOT generate a timeout pulse.
REQ-025 First round-robin arbitration after reset SHALL therefore favour index 0.

Configuration
REQ-026 With ARB_TIMEOUT_EN defined: in GRANT the hold counter counts cycles from 1; when count == L with no release, SHALL force GRANT->GAP and pulse timeout for exactly one cycle (the GAP cycle).
- L = 0 disables the timeout.
- L is sampled on GRANT entry.
- release, or the granted requester dropping req, in the same cycle as count == L: release wins, no timeout pulse.
REQ-027 Without ARB_TIMEOUT_EN: no hold counter; uio_in[7:4] ignored; uo_out[4] constant 0.

Structure
REQ-028 Shared package tt_arb_pkg SHALL hold state encodings (IDLE/GRANT/GAP), N_REQ, CNT_W, and uo_out bit-position constants.
REQ-029 Winner selection SHALL be sub-module arb_pick: combinational masked priority encoder (req, last, mode -> index, any), instantiated once.

Verification
REQ-030 Fixed mode, req=8'b0010_0100 -> one cycle later grant index=5, valid=1, state=1; release=1 -> next cycle valid=0, state=2; next cycle state=0.
REQ-031 Round-robin, req=8'hFF held, release pulsed in each GRANT -> grant sequence 0,1,2,...,7,0 with one GAP cycle between consecutive grants.
REQ-032 Round-robin, last=6, req=8'b0000_0011 -> grant index 0 (wrap-around).
REQ-033 ARB_TIMEOUT_EN defined, L=3, req[2] held, no release -> grant valid exactly 3 cycles, timeout=1 for one cycle, then re-grant index 2; L=0 same stimulus -> grant held indefinitely, no timeout.
REQ-034 Mid-GRANT rst_n=0 for one edge -> uo_out=0 next cycle, last=7; after release of reset, req=8'h81 in round-robin -> grant 0.
